// File: rtl/packet_buffer_reader_pkg.sv
// packet_buffer_reader_pkg: shared packet-buffer constants and the clog2 helper
package packet_buffer_reader_pkg;
   localparam int BYTE_LEN = 8;
   localparam int PACKET_BUFFER_SIZE = 64;
   localparam int PACKET_BUFFER_READ_LATENCY = 2;
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction
endpackage

// File: rtl/packet_buffer_reader_if.sv
// packet_buffer_reader_if: job control, BRAM-driver read port and output byte stream
interface packet_buffer_reader_if
   import packet_buffer_reader_pkg::*;
#(
   parameter int AW = clog2(PACKET_BUFFER_SIZE),
   parameter int DW = BYTE_LEN
);
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic          read_req;
   logic [AW-1:0] read_addr;
   logic          read_ready;
   logic [DW-1:0] read_out;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;
   modport master (
      input  start, start_addr, len, read_ready, read_out, out_ready,
      output busy, done, read_req, read_addr, out_valid, out_data, out_last
   );
   modport slave (
      output start, start_addr, len, read_ready, read_out, out_ready,
      input  busy, done, read_req, read_addr, out_valid, out_data, out_last
   );
endinterface

// File: rtl/packet_buffer_reader_byte_fifo.sv
// byte_fifo: synchronous FIFO with head/count/empty/full, async active-low reset
module byte_fifo
   import packet_buffer_reader_pkg::*;
#(
   parameter int WIDTH = BYTE_LEN,
   parameter int DEPTH = 4,
   localparam int PW = DEPTH > 1 ? clog2(DEPTH) : 1,
   localparam int CW = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   // pointers advance with wrap at DEPTH; push and pop together keep the count
   always_comb begin
      wr_ptr_d = push ? bump(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? bump(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: head is only consumed while non-empty
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = count_q == '0;
   assign full  = count_q == CW'(DEPTH);
endmodule

// File: rtl/packet_buffer_reader.sv
// packet_buffer_reader: credit-based BRAM byte reader; optional PACKET_READER_WRAP_EN wraps addresses at RAM_SIZE
module packet_buffer_reader
   import packet_buffer_reader_pkg::*;
#(
   parameter int RAM_SIZE     = PACKET_BUFFER_SIZE,
   parameter int READ_LATENCY = PACKET_BUFFER_READ_LATENCY,
   parameter int FIFO_DEPTH   = 4
) (
   input logic                    clk,
   input logic                    reset,
   packet_buffer_reader_if.master bus
);
   localparam int AW = clog2(RAM_SIZE);
   localparam int CW = clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        rd_addr_q, rd_addr_d, rd_addr_inc;
   logic [AW:0]          rd_remaining_q, rd_remaining_d;
   logic [AW:0]          out_remaining_q, out_remaining_d;
   logic [CW-1:0]        outstanding_q, outstanding_d;
   logic [CW-1:0]        fifo_count;
   logic [CW:0]          credit;
   logic [BYTE_LEN-1:0]  fifo_head;
   logic                 fifo_empty, fifo_full;
   logic                 accept, issue, push, pop;

   assign accept = state_q == IDLE && bus.start;
   assign pop    = !fifo_empty && bus.out_ready;
   assign push   = bus.read_ready && outstanding_q != '0;
   assign credit = {1'b0, fifo_count} + {1'b0, outstanding_q} - (CW + 1)'(pop);
   assign issue  = state_q == READ && rd_remaining_q != '0 && credit < (CW + 1)'(FIFO_DEPTH);

`ifdef PACKET_READER_WRAP_EN
   assign rd_addr_inc = rd_addr_q == AW'(RAM_SIZE - 1) ? '0 : rd_addr_q + AW'(1);
`else
   assign rd_addr_inc = rd_addr_q + AW'(1);
`endif

   // state register and job counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         rd_addr_q       <= '0;
         rd_remaining_q  <= '0;
         out_remaining_q <= '0;
         outstanding_q   <= '0;
      end else begin
         state_q         <= state_d;
         rd_addr_q       <= rd_addr_d;
         rd_remaining_q  <= rd_remaining_d;
         out_remaining_q <= out_remaining_d;
         outstanding_q   <= outstanding_d;
      end
   end

   // next state: READ until the last read issues, DRAIN until the last byte leaves
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = bus.len == '0 ? DONE : READ;
         READ:    if (issue && rd_remaining_q == (AW + 1)'(1)) state_d = DRAIN;
         DRAIN:   if (pop && out_remaining_q == (AW + 1)'(1)) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // job counters: latched on accepted start, stepped by issue, pop and return
   always_comb begin
      rd_addr_d       = accept ? bus.start_addr : issue ? rd_addr_inc : rd_addr_q;
      rd_remaining_d  = accept ? bus.len : issue ? rd_remaining_q - (AW + 1)'(1) : rd_remaining_q;
      out_remaining_d = accept ? bus.len : pop ? out_remaining_q - (AW + 1)'(1) : out_remaining_q;
      outstanding_d   = outstanding_q + CW'(issue) - CW'(push);
   end

   // outputs decoded from state, counters and FIFO occupancy
   always_comb begin
      bus.busy      = state_q != IDLE;
      bus.done      = state_q == DONE;
      bus.read_req  = issue;
      bus.read_addr = rd_addr_q;
      bus.out_valid = !fifo_empty;
      bus.out_data  = fifo_empty ? '0 : fifo_head;
      bus.out_last  = !fifo_empty && out_remaining_q == (AW + 1)'(1);
   end

   byte_fifo #(
      .WIDTH (BYTE_LEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (bus.read_out),
      .head  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full && !pop));
   a_read_latency: assert property (@(posedge clk) disable iff (!reset) bus.read_req |-> ##READ_LATENCY bus.read_ready);
endmodule

// File: tb/tb_packet_buffer_reader.sv
// tb_packet_buffer_reader: directed jobs checked against a queue-based reader model
module tb_packet_buffer_reader;
   localparam int RAM_SIZE = 64;
   localparam int LAT      = 2;
   localparam int DEPTH    = 4;
   localparam int AW       = 6;
`ifdef PACKET_READER_WRAP_EN
   localparam int RAM_MOD  = RAM_SIZE;
`else
   localparam int RAM_MOD  = 1 << AW;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   packet_buffer_reader_if #(.AW(AW), .DW(8)) bus ();

   packet_buffer_reader #(
      .RAM_SIZE     (RAM_SIZE),
      .READ_LATENCY (LAT),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [RAM_SIZE];
   initial for (int i = 0; i < RAM_SIZE; i++) mem[i] = 8'(i * 3 + 17);

   logic [LAT-1:0] rr_pipe = '0;
   logic [AW-1:0]  ra_pipe [LAT];
   always @(posedge clk) begin
      rr_pipe <= {rr_pipe[LAT-2:0], bus.read_req};
      ra_pipe[0] <= bus.read_addr;
      for (int i = 1; i < LAT; i++) ra_pipe[i] <= ra_pipe[i-1];
   end
   assign bus.read_ready = rr_pipe[LAT-1];
   assign bus.read_out   = mem[ra_pipe[LAT-1]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [AW-1:0] req_log [$];
   logic [7:0]    byte_log [$];
   logic [AW-1:0] exp_a [$];
   logic [7:0]    exp_b [$];
   logic [7:0]    last_byte;
   int done_cnt, busy_cnt, last_cnt, first_req_cyc, first_valid_cyc, last_xfer_cyc, done_cyc;

   task automatic clear_logs();
      req_log.delete();
      byte_log.delete();
      last_byte = 8'h00;
      done_cnt = 0;
      busy_cnt = 0;
      last_cnt = 0;
      first_req_cyc = -1;
      first_valid_cyc = -1;
      last_xfer_cyc = -1;
      done_cyc = -1;
   endtask

   int            m_phase;
   int            m_left;
   logic [AW-1:0] m_issue [$];
   logic [AW-1:0] m_flight [$];
   logic [7:0]    m_fifo [$];
   logic [7:0]    e_data, tmp_b;
   logic [AW-1:0] tmp_a;
   logic          e_valid, e_pop, e_last, e_req;

   initial begin
      clear_logs();
      m_phase = 0;
      m_left = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_phase = 0;
            m_left = 0;
            m_issue.delete();
            m_flight.delete();
            m_fifo.delete();
         end
         e_valid = m_fifo.size() != 0;
         e_data  = e_valid ? m_fifo[0] : 8'h00;
         e_pop   = e_valid && bus.out_ready;
         e_last  = e_valid && m_left == 1;
         e_req   = reset && m_phase == 1 && m_issue.size() != 0 &&
                   (m_fifo.size() + m_flight.size() - int'(e_pop)) < DEPTH;
         chk("busy", 32'(bus.busy), 32'(m_phase != 0));
         chk("done", 32'(bus.done), 32'(m_phase == 2));
         chk("read_req", 32'(bus.read_req), 32'(e_req));
         if (e_req || !reset) chk("read_addr", 32'(bus.read_addr), e_req ? 32'(m_issue[0]) : 32'd0);
         chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
         chk("out_data", 32'(bus.out_data), 32'(e_data));
         chk("out_last", 32'(bus.out_last), 32'(e_last));
         if (bus.read_req) begin
            req_log.push_back(bus.read_addr);
            if (first_req_cyc < 0) first_req_cyc = cyc;
         end
         if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            byte_log.push_back(bus.out_data);
            last_xfer_cyc = cyc;
            if (bus.out_last) begin
               last_cnt++;
               last_byte = bus.out_data;
            end
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.busy) busy_cnt++;
         @(posedge clk);
         if (reset) begin
            if (e_pop) begin
               tmp_b = m_fifo.pop_front();
               m_left--;
            end
            if (bus.read_ready && m_flight.size() != 0) begin
               tmp_a = m_flight.pop_front();
               m_fifo.push_back(mem[tmp_a]);
            end
            if (e_req) m_flight.push_back(m_issue.pop_front());
            if (m_phase == 0 && bus.start) begin
               m_left = int'(bus.len);
               m_phase = bus.len == '0 ? 2 : 1;
               for (int i = 0; i < int'(bus.len); i++)
                  m_issue.push_back(AW'((int'(bus.start_addr) + i) % RAM_MOD));
            end else if (m_phase == 2) m_phase = 0;
            else if (m_phase == 1 && m_left == 0) m_phase = 2;
         end
      end
   end

   int start_cyc;

   task automatic run_job(input int a, input int l, input logic [3:0] ptn, input bit restart);
      clear_logs();
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.start_addr = AW'(a);
      bus.len = (AW + 1)'(l);
      start_cyc = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.start_addr = AW'(50);
      bus.len = (AW + 1)'(2);
      for (int i = 0; i < 200 && done_cnt == 0; i++) begin
         bus.out_ready = ptn[i % 4];
         bus.start = restart && i == 2;
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      chk("job_completed", 32'(done_cnt != 0), 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_job(input string tag);
      chk({tag, "_nreq"}, 32'(req_log.size()), 32'(exp_a.size()));
      chk({tag, "_nbytes"}, 32'(byte_log.size()), 32'(exp_b.size()));
      for (int i = 0; i < exp_a.size() && i < req_log.size(); i++)
         chk({tag, "_addr"}, 32'(req_log[i]), 32'(exp_a[i]));
      for (int i = 0; i < exp_b.size() && i < byte_log.size(); i++)
         chk({tag, "_byte"}, 32'(byte_log[i]), 32'(exp_b[i]));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.start_addr = '0;
      bus.len = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_read_req", 32'(bus.read_req), 32'd0);
      chk("rst_read_addr", 32'(bus.read_addr), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      run_job(10, 5, 4'b1111, 1'b0);
      exp_a = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd14};
      exp_b = '{8'h2F, 8'h32, 8'h35, 8'h38, 8'h3B};
      check_job("job1");
      chk("job1_first_req_delay", 32'(first_req_cyc - start_cyc), 32'd1);
      chk("job1_first_valid_delay", 32'(first_valid_cyc - start_cyc), 32'd4);
      chk("job1_stream_span", 32'(last_xfer_cyc - first_valid_cyc), 32'd4);
      chk("job1_done_after_last", 32'(done_cyc - last_xfer_cyc), 32'd1);
      chk("job1_last_byte", 32'(last_byte), 32'h3B);
      chk("job1_last_count", 32'(last_cnt), 32'd1);

      run_job(10, 5, 4'b1001, 1'b0);
      check_job("job2");
      chk("job2_last_byte", 32'(last_byte), 32'h3B);

      run_job(7, 0, 4'b1111, 1'b0);
      exp_a = {};
      exp_b = {};
      check_job("len0");
      chk("len0_done_delay", 32'(done_cyc - start_cyc), 32'd1);
      chk("len0_busy_cycles", 32'(busy_cnt), 32'd1);

      clear_logs();
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.start_addr = AW'(20);
      bus.len = (AW + 1)'(6);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_read_req", 32'(bus.read_req), 32'd0);
      chk("mid_rst_read_addr", 32'(bus.read_addr), 32'd0);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
      chk("mid_rst_in_flight_seen", 32'(req_log.size()), 32'd2);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("stray_ready_present", 32'(bus.read_ready), 32'd1);
      @(negedge clk);
      chk("stray_ignored_valid", 32'(bus.out_valid), 32'd0);
      chk("stray_ignored_busy", 32'(bus.busy), 32'd0);
      run_job(0, 3, 4'b1111, 1'b0);
      exp_a = '{6'd0, 6'd1, 6'd2};
      exp_b = '{8'h11, 8'h14, 8'h17};
      check_job("post_rst");
      chk("post_rst_last_byte", 32'(last_byte), 32'h17);

      run_job(30, 4, 4'b1111, 1'b1);
      exp_a = '{6'd30, 6'd31, 6'd32, 6'd33};
      exp_b = '{8'h6B, 8'h6E, 8'h71, 8'h74};
      check_job("restart");

`ifdef PACKET_READER_WRAP_EN
      run_job(RAM_SIZE - 2, 4, 4'b1111, 1'b0);
      exp_a = '{6'd62, 6'd63, 6'd0, 6'd1};
      exp_b = '{8'hCB, 8'hCE, 8'h11, 8'h14};
      check_job("wrap");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end
endmodule
